// File: rtl/reg_file_shadow.sv
// Register file with a shadow bank. Four write modes (normal, load-immediate,
// and two fixed-destination copies) and combinational read ports with
// optional same-cycle forwarding. A save/restore engine moves the whole bank
// to or from the shadow copy, one register per cycle.
module reg_file_shadow #(
   parameter int W       = 8,
   parameter int A       = 4,
   parameter int IMM_REG = 3,
   parameter int CPP_REG = 1,
   parameter int CYY_REG = 2,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         WriteEn,
   input  logic [1:0]   Mode,
   input  logic [A-1:0] RaddrA,
   input  logic [A-1:0] RaddrB,
   input  logic [A-1:0] Waddr,
   input  logic [W-1:0] DataIn,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   input  logic         SaveReq,
   input  logic         RestoreReq,
   output logic         Busy,
   output logic         Done
);

   localparam int N = 2 ** A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAVE,
      ST_RESTORE
   } state_t;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'b00,
      MODE_IMM    = 2'b01,
      MODE_CPP    = 2'b10,
      MODE_CYY    = 2'b11
   } mode_t;

   logic [W-1:0] regs   [N];
   logic [W-1:0] shadow [N];

   state_t       state;
   state_t       next_state;
   logic [A-1:0] cnt;
   logic         last_idx;

   logic         wr_en;
   logic         wr_keep;
   logic [A-1:0] wr_addr;
   logic [W-1:0] wr_data;

   assign last_idx = (cnt == A'(N - 1));

   // Architectural write target and data; copies read the pre-edge source.
   always_comb begin
      wr_addr = Waddr;
      wr_data = DataIn;
      unique case (mode_t'(Mode))
         MODE_NORMAL: wr_addr = Waddr;
         MODE_IMM:    wr_addr = A'(IMM_REG);
         MODE_CPP: begin
            wr_addr = A'(CPP_REG);
            wr_data = regs[RaddrA];
         end
         MODE_CYY: begin
            wr_addr = A'(CYY_REG);
            wr_data = regs[RaddrA];
         end
      endcase
   end

   // Writes are locked out during transfers; r0 writes are dropped in zero-r0 mode.
   always_comb begin
      wr_en   = WriteEn && (state == ST_IDLE);
      wr_keep = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));
   end

   // Next-state decode and Busy; SaveReq has priority over RestoreReq.
   always_comb begin
      next_state = state;
      Busy       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (SaveReq)
               next_state = ST_SAVE;
            else if (RestoreReq)
               next_state = ST_RESTORE;
         end
         ST_SAVE, ST_RESTORE: begin
            Busy = 1'b1;
            if (last_idx)
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Transfer index: held at zero while idle, walks 0..N-1 during a transfer.
   always_ff @(posedge Clk) begin
      if (Reset || state == ST_IDLE)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Done pulses for the single cycle after the last index is transferred.
   always_ff @(posedge Clk) begin
      if (Reset)
         Done <= 1'b0;
      else
         Done <= (state != ST_IDLE) && last_idx;
   end

   // Architectural bank: normal writes while idle, shadow copy-back during restore.
   // NOTE: both banks are reset because a cleared register/shadow state is architecturally visible.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N; i++)
            regs[i] <= '0;
      end else begin
         if (wr_keep)
            regs[wr_addr] <= wr_data;
         if (state == ST_RESTORE && !((ZERO_R0 != 0) && (cnt == '0)))
            regs[cnt] <= shadow[cnt];
      end
   end

   // Shadow bank: captures one architectural register per cycle during save.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < N; i++)
            shadow[i] <= '0;
      end else if (state == ST_SAVE) begin
         shadow[cnt] <= regs[cnt];
      end
   end

   // Read ports with optional forwarding of the write in flight.
   always_comb begin
      DataOutA = regs[RaddrA];
      DataOutB = regs[RaddrB];
      if ((BYPASS != 0) && wr_en && (wr_addr == RaddrA))
         DataOutA = wr_data;
      if ((BYPASS != 0) && wr_en && (wr_addr == RaddrB))
         DataOutB = wr_data;
      if ((ZERO_R0 != 0) && (RaddrA == '0))
         DataOutA = '0;
      if ((ZERO_R0 != 0) && (RaddrB == '0))
         DataOutB = '0;
   end

endmodule

// File: tb/tb_reg_file_shadow.sv
// Directed bench for reg_file_shadow: one default instance plus a zero-r0
// instance driven by the same stimulus.
module tb_reg_file_shadow;

   logic       Clk;
   logic       Reset;
   logic       WriteEn;
   logic [1:0] Mode;
   logic [3:0] RaddrA, RaddrB, Waddr;
   logic [7:0] DataIn;
   logic       SaveReq, RestoreReq;

   logic [7:0] out_a, out_b, z_out_a, z_out_b;
   logic       busy, done, z_busy, z_done;

   int checks = 0;
   int errors = 0;
   int busy_n, done_n;

   reg_file_shadow dut (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Mode(Mode),
      .RaddrA(RaddrA), .RaddrB(RaddrB), .Waddr(Waddr), .DataIn(DataIn),
      .DataOutA(out_a), .DataOutB(out_b),
      .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(busy), .Done(done)
   );

   reg_file_shadow #(.ZERO_R0(1)) dut_z (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Mode(Mode),
      .RaddrA(RaddrA), .RaddrB(RaddrB), .Waddr(Waddr), .DataIn(DataIn),
      .DataOutA(z_out_a), .DataOutB(z_out_b),
      .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(z_busy), .Done(z_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clk_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in();
      WriteEn    = 1'b0;
      SaveReq    = 1'b0;
      RestoreReq = 1'b0;
      Mode       = 2'b00;
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
      Mode    = 2'b00;
      Waddr   = addr;
      DataIn  = data;
      WriteEn = 1'b1;
      clk_step();
      WriteEn = 1'b0;
   endtask

   task automatic pulse_save();
      SaveReq = 1'b1;
      clk_step();
      SaveReq = 1'b0;
   endtask

   task automatic pulse_restore();
      RestoreReq = 1'b1;
      clk_step();
      RestoreReq = 1'b0;
   endtask

   // Reads both ports of the default instance and port A of the zero-r0 instance.
   task automatic read_chk(input string tag, input logic [3:0] addr,
                           input logic [7:0] exp, input logic [7:0] exp_z);
      @(negedge Clk);
      RaddrA = addr;
      RaddrB = addr;
      #1;
      check({tag, "_a"}, out_a, exp);
      check({tag, "_b"}, out_b, exp);
      check({tag, "_z"}, z_out_a, exp_z);
   endtask

   // Samples a bounded window, counting Busy cycles and Done pulses.
   task automatic wait_xfer(output int b, output int d);
      b = 0;
      d = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) b++;
         if (done) d++;
         clk_step();
      end
   endtask

   initial begin
      idle_in();
      Reset  = 1'b1;
      RaddrA = '0;
      RaddrB = '0;
      Waddr  = '0;
      DataIn = '0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      read_chk("rst_r5", 4'd5, 8'h00, 8'h00);

      // Normal write with same-cycle forwarding on A, B reading another index
      Mode = 2'b00; Waddr = 4'd7; DataIn = 8'hA5; WriteEn = 1'b1;
      RaddrA = 4'd7; RaddrB = 4'd4;
      #1;
      check("byp_a", out_a, 8'hA5);
      check("byp_b_other", out_b, 8'h00);
      clk_step();
      WriteEn = 1'b0;
      read_chk("wr_r7", 4'd7, 8'hA5, 8'hA5);

      // Load-immediate lands in r3, not at Waddr
      Mode = 2'b01; Waddr = 4'd7; DataIn = 8'h3C; WriteEn = 1'b1;
      clk_step();
      idle_in();
      read_chk("imm_r3", 4'd3, 8'h3C, 8'h3C);
      read_chk("imm_r7", 4'd7, 8'hA5, 8'hA5);

      // Copy r3 -> r1, forwarded onto B in the same cycle
      @(negedge Clk);
      Mode = 2'b10; RaddrA = 4'd3; RaddrB = 4'd1; DataIn = 8'h00; WriteEn = 1'b1;
      #1;
      check("cpp_byp_b", out_b, 8'h3C);
      clk_step();
      idle_in();
      read_chk("cpp_r1", 4'd1, 8'h3C, 8'h3C);

      // Copy r1 -> r2
      Mode = 2'b11; RaddrA = 4'd1; WriteEn = 1'b1;
      clk_step();
      idle_in();
      read_chk("cyy_r2", 4'd2, 8'h3C, 8'h3C);

      // Fill, save, clear, restore
      for (int k = 0; k < 16; k++) write_reg(4'(k), 8'(k + 8'h10));
      pulse_save();
      wait_xfer(busy_n, done_n);
      check("save_busy_n", busy_n, 16);
      check("save_done_n", done_n, 1);
      for (int k = 0; k < 16; k++) write_reg(4'(k), 8'h00);
      read_chk("clr_r5", 4'd5, 8'h00, 8'h00);
      pulse_restore();
      RaddrA = 4'd9;
      #1;
      check("rst_old_r9", out_a, 8'h00);
      wait_xfer(busy_n, done_n);
      check("rest_busy_n", busy_n, 16);
      check("rest_done_n", done_n, 1);
      for (int k = 0; k < 16; k++)
         read_chk("rest_rk", 4'(k), 8'(k + 8'h10), (k == 0) ? 8'h00 : 8'(k + 8'h10));

      // Simultaneous requests with a same-cycle write; ignored requests/writes while busy
      write_reg(4'd4, 8'h99);
      Mode = 2'b00; Waddr = 4'd6; DataIn = 8'h66; WriteEn = 1'b1;
      SaveReq = 1'b1; RestoreReq = 1'b1;
      clk_step();
      idle_in();
      check("both_busy", busy, 1);
      RestoreReq = 1'b1; WriteEn = 1'b1; Waddr = 4'd8; DataIn = 8'hEE;
      clk_step();
      idle_in();
      wait_xfer(busy_n, done_n);
      check("both_busy_n", busy_n, 15);
      check("both_done_n", done_n, 1);
      check("no_queue_busy", busy, 0);
      read_chk("busy_wr_r8", 4'd8, 8'h18, 8'h18);
      read_chk("same_cyc_r6", 4'd6, 8'h66, 8'h66);
      read_chk("save_won_r4", 4'd4, 8'h99, 8'h99);
      write_reg(4'd4, 8'h00);
      write_reg(4'd6, 8'h00);
      pulse_restore();
      wait_xfer(busy_n, done_n);
      read_chk("shadow_r4", 4'd4, 8'h99, 8'h99);
      read_chk("shadow_r6", 4'd6, 8'h66, 8'h66);

      // Reset in the middle of a save
      pulse_save();
      repeat (5) clk_step();
      Reset = 1'b1;
      clk_step();
      Reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      wait_xfer(busy_n, done_n);
      check("abort_busy_n", busy_n, 0);
      check("abort_done_n", done_n, 0);
      read_chk("abort_r4", 4'd4, 8'h00, 8'h00);
      read_chk("abort_r9", 4'd9, 8'h00, 8'h00);
      write_reg(4'd7, 8'h77);
      pulse_restore();
      wait_xfer(busy_n, done_n);
      check("abort_rest_done_n", done_n, 1);
      read_chk("abort_shadow_r7", 4'd7, 8'h00, 8'h00);

      // Zero-r0: writes dropped, forwarding suppressed, restore leaves r0 zero
      @(negedge Clk);
      Mode = 2'b00; Waddr = 4'd0; DataIn = 8'hFF; WriteEn = 1'b1;
      RaddrA = 4'd0; RaddrB = 4'd0;
      #1;
      check("r0_byp", out_a, 8'hFF);
      check("r0_byp_z_a", z_out_a, 8'h00);
      check("r0_byp_z_b", z_out_b, 8'h00);
      clk_step();
      idle_in();
      read_chk("r0_wr", 4'd0, 8'hFF, 8'h00);
      pulse_save();
      wait_xfer(busy_n, done_n);
      write_reg(4'd0, 8'h11);
      pulse_restore();
      wait_xfer(busy_n, done_n);
      check("z_rest_done_n", z_done, 0);
      read_chk("r0_rest", 4'd0, 8'hFF, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
